// File: rtl/fpgen_pkg.sv
// Shared types and widths for the burst pulse engine.
// The channel config struct is fixed-width, so these widths govern the top-level parameters.
package fpgen_pkg;

    localparam int unsigned NUM_TRIGGERS = 2;
    localparam int unsigned COARSE_W     = 5;
    localparam int unsigned FINE_W       = 12;
    localparam int unsigned LENGTH_W     = 16;
    localparam int unsigned BURST_W      = 8;
    localparam int unsigned TRIG_SEL_W   = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;
    // Phase counter must hold a full length+1 period as well as any coarse delay.
    localparam int unsigned CNT_W        = (LENGTH_W + 1 > COARSE_W) ? LENGTH_W + 1 : COARSE_W;
    localparam int unsigned REM_W        = 16;

    typedef struct packed {
        logic [FINE_W-1:0]     fine;
        logic                  pol;
        logic [COARSE_W-1:0]   coarse;
        logic [LENGTH_W-1:0]   length;
        logic [BURST_W-1:0]    period;
        logic [BURST_W-1:0]    burst;
        logic                  cont;
        logic [TRIG_SEL_W-1:0] trig_sel;
    } fpgen_ch_cfg_t;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StPulse,
        StGap
    } fpgen_state_t;

    // Pulse start spacing: never closer than length+1, so a gap cycle always separates pulses.
    function automatic logic [CNT_W-1:0] eff_period(input logic [BURST_W-1:0]  period,
                                                    input logic [LENGTH_W-1:0] length);
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] l1;
        p  = CNT_W'(period);
        l1 = CNT_W'(length) + CNT_W'(1);
        return (p > l1) ? p : l1;
    endfunction

endpackage

// File: rtl/fpgen_channel.sv
// One pulse channel: shadowed config, IDLE/DELAY/PULSE/GAP sequencer, registered outputs.
// Outputs are registered from next-state so they line up with the state they describe.
module fpgen_channel
    import fpgen_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  fpgen_ch_cfg_t     cfg_i,
    output logic              pulse_o,
    output logic [FINE_W-1:0] fine_o,
    output logic              fine_valid_o,
    output logic              ready_o
);

    fpgen_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [FINE_W-1:0] sh_fine_q, sh_fine_d;
    logic              sh_pol_q, sh_pol_d;
    logic              sh_len_zero_q, sh_len_zero_d;
    logic              sh_cont_q, sh_cont_d;
    logic [CNT_W-1:0]  sh_plen_q, sh_plen_d;
    logic [CNT_W-1:0]  sh_gap_q, sh_gap_d;
    logic              pulse_q, pulse_d;
    logic              fv_q, fv_d;
    logic              ready_q, ready_d;
    logic [FINE_W-1:0] fine_q, fine_d;
    logic [CNT_W-1:0]  cfg_plen;
    logic [CNT_W-1:0]  cfg_gap;
    logic              unused_trig_sel;

    // Trigger selection is resolved by the top; the channel only sees start_i.
    assign unused_trig_sel = ^cfg_i.trig_sel;

    // A zero-length pulse still occupies one PULSE cycle, just without an active level.
    assign cfg_plen = (cfg_i.length == '0) ? CNT_W'(1) : CNT_W'(cfg_i.length);
    assign cfg_gap  = eff_period(cfg_i.period, cfg_i.length) - cfg_plen;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        sh_fine_d     = sh_fine_q;
        sh_pol_d      = sh_pol_q;
        sh_len_zero_d = sh_len_zero_q;
        sh_cont_d     = sh_cont_q;
        sh_plen_d     = sh_plen_q;
        sh_gap_d      = sh_gap_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    sh_fine_d     = cfg_i.fine;
                    sh_pol_d      = cfg_i.pol;
                    sh_len_zero_d = (cfg_i.length == '0);
                    sh_cont_d     = cfg_i.cont;
                    sh_plen_d     = cfg_plen;
                    sh_gap_d      = cfg_gap;
                    rem_d         = (cfg_i.burst > BURST_W'(1)) ? REM_W'(cfg_i.burst)
                                                                : REM_W'(1);
                    if (cfg_i.coarse != '0) begin
                        state_d = StDelay;
                        cnt_d   = CNT_W'(cfg_i.coarse) - CNT_W'(1);
                    end else begin
                        state_d = StPulse;
                        cnt_d   = cfg_plen - CNT_W'(1);
                    end
                end
            end
            StDelay, StGap: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = sh_plen_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StPulse: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!sh_cont_q && rem_q <= REM_W'(1)) begin
                    state_d = StIdle;
                end else begin
                    if (!sh_cont_q) begin
                        rem_d = rem_q - REM_W'(1);
                    end
                    if (sh_gap_q == '0) begin
                        state_d = StPulse;
                        cnt_d   = sh_plen_q - CNT_W'(1);
                    end else begin
                        state_d = StGap;
                        cnt_d   = sh_gap_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort_i) begin
            state_d = StIdle;
        end

        // In IDLE the live polarity applies; while running, the shadowed one.
        if (state_d == StIdle) begin
            pulse_d = cfg_i.pol;
        end else if (state_d == StPulse && !sh_len_zero_d) begin
            pulse_d = ~sh_pol_d;
        end else begin
            pulse_d = sh_pol_d;
        end

        fv_d    = (state_d == StPulse) && (state_q != StPulse) && !sh_len_zero_d;
        fine_d  = fv_d ? sh_fine_d : fine_q;
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            sh_fine_q     <= '0;
            sh_pol_q      <= 1'b0;
            sh_len_zero_q <= 1'b0;
            sh_cont_q     <= 1'b0;
            sh_plen_q     <= '0;
            sh_gap_q      <= '0;
            pulse_q       <= 1'b0;
            fv_q          <= 1'b0;
            ready_q       <= 1'b1;
            fine_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            sh_fine_q     <= sh_fine_d;
            sh_pol_q      <= sh_pol_d;
            sh_len_zero_q <= sh_len_zero_d;
            sh_cont_q     <= sh_cont_d;
            sh_plen_q     <= sh_plen_d;
            sh_gap_q      <= sh_gap_d;
            pulse_q       <= pulse_d;
            fv_q          <= fv_d;
            ready_q       <= ready_d;
            fine_q        <= fine_d;
        end
    end

    assign pulse_o      = pulse_q;
    assign fine_o       = fine_q;
    assign fine_valid_o = fv_q;
    assign ready_o      = ready_q;

endmodule

// File: rtl/fpgen_burst_channels.sv
// N-channel coarse-timing burst pulse engine: per-channel trigger select, sequencer and
// sticky overrun flag.
module fpgen_burst_channels
    import fpgen_pkg::*;
#(
    parameter int unsigned G_NUM_CHANNELS = 6,
    parameter int unsigned G_NUM_TRIGGERS = 2,
    parameter int unsigned G_COARSE_W     = 5,
    parameter int unsigned G_FINE_W       = 12,
    parameter int unsigned G_LENGTH_W     = 16,
    parameter int unsigned G_BURST_W      = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [G_NUM_TRIGGERS-1:0]                trig_i,
    input  logic [G_NUM_CHANNELS-1:0]                force_i,
    input  logic [G_NUM_CHANNELS-1:0]                abort_i,
    input  fpgen_ch_cfg_t [G_NUM_CHANNELS-1:0]       cfg_i,
    output logic [G_NUM_CHANNELS-1:0]                pulse_o,
    output logic [G_NUM_CHANNELS-1:0][G_FINE_W-1:0]  fine_o,
    output logic [G_NUM_CHANNELS-1:0]                fine_valid_o,
    output logic [G_NUM_CHANNELS-1:0]                ready_o,
    output logic [G_NUM_CHANNELS-1:0]                overrun_o
);

    // The config struct has fixed field widths; the parameters must agree with them.
    if (G_COARSE_W != COARSE_W || G_FINE_W != FINE_W || G_LENGTH_W != LENGTH_W ||
        G_BURST_W != BURST_W || G_NUM_TRIGGERS != NUM_TRIGGERS ||
        G_NUM_CHANNELS < 1 || G_NUM_CHANNELS > 16) begin : g_param_check
        $error("fpgen_burst_channels: parameters disagree with fpgen_pkg widths");
    end

    logic [G_NUM_CHANNELS-1:0] start;
    logic [G_NUM_CHANNELS-1:0] overrun_q, overrun_d;

    for (genvar c = 0; c < G_NUM_CHANNELS; c++) begin : g_ch
        assign start[c] = trig_i[cfg_i[c].trig_sel] | force_i[c];

        fpgen_channel u_channel (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .start_i      (start[c]),
            .abort_i      (abort_i[c]),
            .cfg_i        (cfg_i[c]),
            .pulse_o      (pulse_o[c]),
            .fine_o       (fine_o[c]),
            .fine_valid_o (fine_valid_o[c]),
            .ready_o      (ready_o[c])
        );
    end

    // Abort clears outright; a start while busy sets, and beats the clear from force.
    always_comb begin
        overrun_d = overrun_q;
        for (int c = 0; c < G_NUM_CHANNELS; c++) begin
            if (abort_i[c]) begin
                overrun_d[c] = 1'b0;
            end else if (start[c] && !ready_o[c]) begin
                overrun_d[c] = 1'b1;
            end else if (force_i[c]) begin
                overrun_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fpgen_burst_channels.sv
// Directed bench for fpgen_burst_channels; expected waveforms are hand-derived cycle windows.
module tb_fpgen_burst_channels;
    import fpgen_pkg::*;

    localparam int NC = 6;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [1:0]                    trig;
    logic [NC-1:0]                 force_v;
    logic [NC-1:0]                 abort_v;
    fpgen_ch_cfg_t [NC-1:0]        cfg;
    logic [NC-1:0]                 pulse;
    logic [NC-1:0][FINE_W-1:0]     fine;
    logic [NC-1:0]                 fv;
    logic [NC-1:0]                 ready;
    logic [NC-1:0]                 overrun;

    int n_checks = 0;
    int n_errors = 0;
    int fv_count;

    fpgen_burst_channels dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .trig_i       (trig),
        .force_i      (force_v),
        .abort_i      (abort_v),
        .cfg_i        (cfg),
        .pulse_o      (pulse),
        .fine_o       (fine),
        .fine_valid_o (fv),
        .ready_o      (ready),
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released and all channels on trig_sel 1.
    task automatic do_reset;
        rst     = 1'b1;
        trig    = '0;
        force_v = '0;
        abort_v = '0;
        for (int i = 0; i < NC; i++) begin
            cfg[i]          = '0;
            cfg[i].trig_sel = 1'b1;
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // Continuous burst on ch0, stopped at cycle 12 by abort or by reset.
    task automatic run_stop(input bit use_rst);
        string t;
        t = use_rst ? "rst" : "abort";
        do_reset();
        cfg[0].cont   = 1'b1;
        cfg[0].burst  = 8'd1;
        cfg[0].length = 16'd3;
        cfg[0].period = 8'd5;
        cfg[0].fine   = 12'h5a5;
        for (int c = 0; c <= 15; c++) begin
            force_v[0] = (c == 0 || c == 3);
            abort_v[0] = !use_rst && (c == 12);
            rst        = use_rst && (c == 12);
            @(negedge clk);
            check_eq($sformatf("%s pulse c%0d", t, c), 32'(pulse[0]),
                     32'(c >= 1 && c <= 12 && ((c - 1) % 5) < 3));
            check_eq($sformatf("%s ready c%0d", t, c), 32'(ready[0]), 32'(c == 0 || c >= 13));
            check_eq($sformatf("%s overrun c%0d", t, c), 32'(overrun[0]),
                     32'(c >= 4 && c <= 12));
            check_eq($sformatf("%s fv c%0d", t, c), 32'(fv[0]),
                     32'(c == 1 || c == 6 || c == 11));
            if (c == 13) begin
                check_eq($sformatf("%s fine c13", t), 32'(fine[0]),
                         use_rst ? 32'h0 : 32'h5a5);
            end
            next_cycle();
        end
        rst        = 1'b0;
        force_v[0] = 1'b0;
        abort_v[0] = 1'b0;
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        rst     = 1'b1;
        trig    = '0;
        force_v = '0;
        abort_v = '0;
        cfg     = '0;
        next_cycle();
        @(negedge clk);
        check_eq("reset pulse", 32'(pulse), 32'h0);
        check_eq("reset fine", 32'(fine[0]), 32'h0);
        check_eq("reset fv", 32'(fv), 32'h0);
        check_eq("reset ready", 32'(ready), 32'h3f);
        check_eq("reset overrun", 32'(overrun), 32'h0);

        // Single pulse: coarse 3, length 4, trig_i[0] at cycle 10.
        do_reset();
        cfg[0].coarse   = 5'd3;
        cfg[0].length   = 16'd4;
        cfg[0].fine     = 12'h3c5;
        cfg[0].trig_sel = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            trig = (c == 10) ? 2'b01 : 2'b00;
            @(negedge clk);
            check_eq($sformatf("single pulse c%0d", c), 32'(pulse[0]), 32'(c >= 14 && c <= 17));
            check_eq($sformatf("single fv c%0d", c), 32'(fv[0]), 32'(c == 14));
            check_eq($sformatf("single ready c%0d", c), 32'(ready[0]), 32'(!(c >= 11 && c <= 17)));
            if (c == 15) check_eq("single fine", 32'(fine[0]), 32'h3c5);
            if (c == 12) check_eq("single other ready", 32'(ready[NC-1:1]), 32'h1f);
            next_cycle();
        end

        // Burst of 3, length 2, period 10, force at 0.
        do_reset();
        cfg[0].length = 16'd2;
        cfg[0].period = 8'd10;
        cfg[0].burst  = 8'd3;
        fv_count      = 0;
        for (int c = 0; c <= 25; c++) begin
            force_v[0] = (c == 0);
            @(negedge clk);
            if (fv[0]) fv_count++;
            check_eq($sformatf("burst pulse c%0d", c), 32'(pulse[0]),
                     32'((c >= 1 && c <= 2) || (c >= 11 && c <= 12) || (c >= 21 && c <= 22)));
            check_eq($sformatf("burst ready c%0d", c), 32'(ready[0]), 32'(c == 0 || c >= 23));
            next_cycle();
        end
        check_eq("burst fv count", 32'(fv_count), 32'd3);

        // Period clamp (eff 6) with inverted polarity.
        do_reset();
        cfg[0].pol    = 1'b1;
        cfg[0].length = 16'd5;
        cfg[0].period = 8'd3;
        cfg[0].burst  = 8'd2;
        next_cycle();
        next_cycle();
        for (int c = 0; c <= 13; c++) begin
            force_v[0] = (c == 0);
            @(negedge clk);
            check_eq($sformatf("clamp pulse c%0d", c), 32'(pulse[0]),
                     32'(!((c >= 1 && c <= 5) || (c >= 7 && c <= 11))));
            check_eq($sformatf("clamp fv c%0d", c), 32'(fv[0]), 32'(c == 1 || c == 7));
            check_eq($sformatf("clamp ready c%0d", c), 32'(ready[0]), 32'(c == 0 || c >= 12));
            next_cycle();
        end

        // Overrun and config shadow.
        do_reset();
        cfg[0].coarse   = 5'd20;
        cfg[0].length   = 16'd4;
        cfg[0].fine     = 12'habc;
        cfg[0].trig_sel = 1'b0;
        for (int c = 0; c <= 43; c++) begin
            trig       = (c == 0 || c == 5) ? 2'b01 : 2'b00;
            force_v[0] = (c == 40 || c == 42);
            if (c == 1) begin
                cfg[0].length = 16'd9;
                cfg[0].fine   = 12'h123;
            end
            @(negedge clk);
            check_eq($sformatf("ovr overrun c%0d", c), 32'(overrun[0]),
                     32'((c >= 6 && c <= 40) || c == 43));
            check_eq($sformatf("ovr pulse c%0d", c), 32'(pulse[0]), 32'(c >= 21 && c <= 24));
            check_eq($sformatf("ovr ready c%0d", c), 32'(ready[0]),
                     32'(c == 0 || (c >= 25 && c <= 40)));
            check_eq($sformatf("ovr fv c%0d", c), 32'(fv[0]), 32'(c == 21));
            if (c == 22) check_eq("ovr fine", 32'(fine[0]), 32'habc);
            next_cycle();
        end

        run_stop(1'b0);
        run_stop(1'b1);

        // Multichannel select; ch5 has length 0.
        do_reset();
        for (int i = 0; i < NC; i++) begin
            cfg[i].trig_sel = 1'(i % 2);
            cfg[i].coarse   = 5'd1;
            cfg[i].length   = (i == 5) ? 16'd0 : 16'd2;
        end
        for (int c = 0; c <= 5; c++) begin
            trig = (c == 0) ? 2'b10 : 2'b00;
            @(negedge clk);
            check_eq($sformatf("multi pulse c%0d", c), 32'(pulse),
                     (c == 2 || c == 3) ? 32'h0a : 32'h0);
            check_eq($sformatf("multi fv c%0d", c), 32'(fv), (c == 2) ? 32'h0a : 32'h0);
            check_eq($sformatf("multi ready c%0d", c), 32'(ready),
                     (c == 1 || c == 2) ? 32'h15 : (c == 3) ? 32'h35 : 32'h3f);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
